// File: rtl/fwd_arb_pkg.sv
// fwd_arb_pkg: shared FSM states and width helper for the forwarder-side arbiter.
package fwd_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_BUSY} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/fwd_arb_rr_select.sv
// fwd_arb_rr_select: round-robin pick of the first request at or after last+1, wrapping.
module fwd_arb_rr_select import fwd_arb_pkg::*; #(
  parameter int N = 4,
  parameter int TAG_SZ = clog2(N)
) (
  input  logic [N-1:0]      i_req,
  input  logic [TAG_SZ-1:0] i_last,
  output logic [TAG_SZ-1:0] o_tag,
  output logic              o_vld
);
  int k;
  always_comb begin
    o_tag = '0;
    o_vld = |i_req;
    k = 0;
    // Walk farthest-first so the nearest request after last is the final assignment.
    for (int i = N; i >= 1; i--) begin
      k = (int'(i_last) + i) % N;
      if (|((i_req >> k) & N'(1))) o_tag = TAG_SZ'(k);
    end
  end
endmodule

// File: rtl/fwd_arb.sv
// fwd_arb: locks the forwarder onto one ready core per packet, chosen round-robin,
// and steers reads, done and accept strobes to that core only.
module fwd_arb import fwd_arb_pkg::*; #(
  parameter int N = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int PLEN_WIDTH = 32,
  parameter int TAG_SZ = clog2(N),
  parameter int OUT_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_data_vld,
  output logic [PLEN_WIDTH-1:0]   byte_len,
  input  logic                    done,
  output logic                    done_ack,
  output logic                    rdy,
  input  logic                    ack,
  output logic [ADDR_WIDTH-1:0]   fwd_addr_i,
  output logic [N-1:0]            fwd_rd_en_i,
  input  logic [N*DATA_WIDTH-1:0] fwd_rd_data_i,
  input  logic [N-1:0]            fwd_rd_data_vld_i,
  input  logic [N*PLEN_WIDTH-1:0] fwd_byte_len_i,
  output logic [N-1:0]            fwd_done_i,
  input  logic [N-1:0]            fwd_done_ack_i,
  input  logic [N-1:0]            rdy_for_fwd_i,
  output logic [N-1:0]            rdy_for_fwd_ack_i
);
  state_t r_state, w_next;
  logic [TAG_SZ-1:0] r_tag, r_last, w_sel;
  logic w_sel_vld, w_idle, w_offer, w_busy, w_done_hs, w_vld;
  logic [N-1:0] w_onehot;
  logic [DATA_WIDTH-1:0] w_data;
  logic [PLEN_WIDTH-1:0] w_len;

  fwd_arb_rr_select #(.N(N), .TAG_SZ(TAG_SZ)) u_rr (
    .i_req (rdy_for_fwd_i),
    .i_last(r_last),
    .o_tag (w_sel),
    .o_vld (w_sel_vld)
  );

  assign w_idle = r_state == ST_IDLE;
  assign w_offer = r_state == ST_OFFER;
  assign w_busy = r_state == ST_BUSY;
  assign w_onehot = N'(1) << r_tag;
  assign w_done_hs = w_busy & done & fwd_done_ack_i[r_tag];

  always_comb begin
    w_next = r_state;
    if (w_idle && w_sel_vld) w_next = ST_OFFER;
    if (w_offer) w_next = ack ? ST_BUSY : (rdy_for_fwd_i[r_tag] ? ST_OFFER : ST_IDLE);
    if (w_done_hs) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tag <= '0;
      r_last <= TAG_SZ'(N - 1);
    end else begin
      r_state <= w_next;
      if (w_idle && w_sel_vld) r_tag <= w_sel;
      if (w_done_hs) r_last <= r_tag;
    end
  end

  assign fwd_addr_i = addr;
  assign rdy = w_offer;
  assign rdy_for_fwd_ack_i = {N{w_offer & ack}} & w_onehot;
  assign fwd_rd_en_i = {N{w_busy & rd_en}} & w_onehot;
  assign fwd_done_i = {N{w_busy & done}} & w_onehot;
  assign done_ack = w_busy & fwd_done_ack_i[r_tag];
  assign w_data = w_busy ? fwd_rd_data_i[r_tag*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign w_vld = w_busy & fwd_rd_data_vld_i[r_tag];
  assign w_len = (w_offer | w_busy) ? fwd_byte_len_i[r_tag*PLEN_WIDTH +: PLEN_WIDTH] : '0;

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] r_data;
      logic [PLEN_WIDTH-1:0] r_len;
      logic r_vld;
      always_ff @(posedge clk) begin
        r_data <= (rst || w_idle) ? '0 : w_data;
        r_vld <= (rst || w_idle) ? 1'b0 : w_vld;
        r_len <= (rst || w_idle) ? '0 : w_len;
      end
      assign rd_data = r_data;
      assign rd_data_vld = r_vld;
      assign byte_len = r_len;
    end else begin : g_comb
      assign rd_data = w_data;
      assign rd_data_vld = w_vld;
      assign byte_len = w_len;
    end
  endgenerate
endmodule

// File: tb/tb_fwd_arb.sv
// tb_fwd_arb: randomized and directed checks of fwd_arb against a round-robin service model.
module tb_fwd_arb;
  localparam int N = 4;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int PW = 32;

  logic clk, rst, rd_en, done, ack;
  logic [AW-1:0] addr;
  logic [N-1:0] rdy_i, dack_i;
  logic [PW-1:0] lens [N];
  logic [N*PW-1:0] fbl;
  logic [N*DW-1:0] c_data;
  logic [N-1:0] c_vld;

  logic [DW-1:0] rd_data, rd_data1;
  logic rd_vld, rd_vld1, done_ack, done_ack1, rdy, rdy1;
  logic [PW-1:0] byte_len, byte_len1;
  logic [AW-1:0] f_addr, f_addr1;
  logic [N-1:0] f_rd_en, f_rd_en1, f_done, f_done1, ack_o, ack_o1;

  int checks = 0;
  int failures = 0;
  int last_srv = N - 1;
  int rbase = 0;

  fwd_arb #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PW), .OUT_REG(0)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_data_vld(rd_vld), .byte_len(byte_len), .done(done), .done_ack(done_ack),
    .rdy(rdy), .ack(ack), .fwd_addr_i(f_addr), .fwd_rd_en_i(f_rd_en),
    .fwd_rd_data_i(c_data), .fwd_rd_data_vld_i(c_vld), .fwd_byte_len_i(fbl),
    .fwd_done_i(f_done), .fwd_done_ack_i(dack_i), .rdy_for_fwd_i(rdy_i),
    .rdy_for_fwd_ack_i(ack_o)
  );

  fwd_arb #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PLEN_WIDTH(PW), .OUT_REG(1)) dut_r (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .rd_data(rd_data1),
    .rd_data_vld(rd_vld1), .byte_len(byte_len1), .done(done), .done_ack(done_ack1),
    .rdy(rdy1), .ack(ack), .fwd_addr_i(f_addr1), .fwd_rd_en_i(f_rd_en1),
    .fwd_rd_data_i(c_data), .fwd_rd_data_vld_i(c_vld), .fwd_byte_len_i(fbl),
    .fwd_done_i(f_done1), .fwd_done_ack_i(dack_i), .rdy_for_fwd_i(rdy_i),
    .rdy_for_fwd_ack_i(ack_o1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always_comb for (int k = 0; k < N; k++) fbl[k*PW +: PW] = lens[k];

  function automatic logic [DW-1:0] mk(input int k, input logic [AW-1:0] a);
    return {16'hC0DE, 8'(k), 32'h1234_5678, a};
  endfunction

  // Cores answer a read one cycle after their strobe.
  always @(posedge clk) begin
    c_vld <= rst ? '0 : f_rd_en;
    for (int k = 0; k < N; k++)
      if (f_rd_en[k]) c_data[k*DW +: DW] <= mk(k, f_addr);
  end

  always @(negedge clk) if (!rst) begin
    checks++;
    if (!$onehot0(f_rd_en) || !$onehot0(f_done) || !$onehot0(ack_o) || !$onehot0(f_rd_en1)) begin
      failures++;
      $display("FAIL onehot0 rd_en=%b done=%b ack=%b rd_en_r=%b", f_rd_en, f_done, ack_o, f_rd_en1);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++)
      if (req[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic do_reset;
    rst = 1; rd_en = 0; done = 0; ack = 0; addr = '0; dack_i = '0; rdy_i = '0;
    tick; tick;
    rst = 0;
    last_srv = N - 1;
  endtask

  task automatic serve(input int nreads, input int dly, output int got);
    int want, w;
    logic [N-1:0] oh;
    want = model_pick(rdy_i, last_srv);
    got = -1;
    w = 0;
    while (rdy !== 1'b1 && w < 6) begin tick; w++; end
    checks++;
    if (rdy !== 1'b1 || want < 0) begin
      failures++;
      $display("FAIL serve_offer rdy=%b want_core=%0d", rdy, want);
      return;
    end
    oh = N'(1) << want;
    checks++;
    if (byte_len !== lens[want] || ack_o !== '0) begin
      failures++;
      $display("FAIL offer_len got=%h/%b want=%h/0", byte_len, ack_o, lens[want]);
    end
    ack = 1;
    #1;
    checks++;
    if (ack_o !== oh) begin
      failures++;
      $display("FAIL grant got=%b want=%b", ack_o, oh);
    end
    got = want;
    tick;
    ack = 0;
    for (int r = 0; r < nreads; r++) begin
      addr = AW'(r + rbase);
      rd_en = 1;
      #1;
      checks++;
      if (f_rd_en !== oh || f_addr !== addr) begin
        failures++;
        $display("FAIL rd_strobe got=%b/%h want=%b/%h", f_rd_en, f_addr, oh, addr);
      end
      tick;
      rd_en = 0;
      #1;
      checks++;
      if (rd_vld !== 1'b1 || rd_data !== mk(want, AW'(r + rbase))) begin
        failures++;
        $display("FAIL rd_data got=%b/%h want=1/%h", rd_vld, rd_data, mk(want, AW'(r + rbase)));
      end
    end
    done = 1;
    for (int d = 0; d < dly; d++) begin
      #1;
      checks++;
      if (done_ack !== 1'b0 || f_done !== oh) begin
        failures++;
        $display("FAIL done_wait got=%b/%b want=0/%b", done_ack, f_done, oh);
      end
      tick;
    end
    dack_i = oh;
    #1;
    checks++;
    if (done_ack !== 1'b1) begin
      failures++;
      $display("FAIL done_ack got=%b want=1", done_ack);
    end
    tick;
    done = 0;
    dack_i = '0;
    #1;
    checks++;
    if (rdy !== 1'b0 || byte_len !== '0) begin
      failures++;
      $display("FAIL post_done rdy=%b len=%h want=0/0", rdy, byte_len);
    end
    last_srv = want;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    checks++;
    if ({rdy, done_ack, rd_vld, rdy1, done_ack1, rd_vld1} !== '0 || rd_data !== '0 ||
        byte_len !== '0 || rd_data1 !== '0 || byte_len1 !== '0 ||
        {f_rd_en, f_done, ack_o} !== '0) begin
      failures++;
      $display("FAIL reset_state rdy=%b dack=%b vld=%b data=%h len=%h strobes=%b",
               rdy, done_ack, rd_vld, rd_data, byte_len, {f_rd_en, f_done, ack_o});
    end
  endtask

  task automatic test_single_core;
    int g;
    do_reset;
    rdy_i = 4'b0100;
    rbase = 0;
    serve(3, 0, g);
    checks++;
    if (g !== 2) begin failures++; $display("FAIL single_core got=%0d want=2", g); end
    rdy_i = '0;
  endtask

  task automatic test_round_robin;
    int g;
    do_reset;
    rdy_i = 4'hF;
    for (int p = 0; p < 8; p++) begin
      rbase = p * 16;
      serve(1, 0, g);
      checks++;
      if (g !== p % 4) begin failures++; $display("FAIL rr_order pkt=%0d got=%0d want=%0d", p, g, p % 4); end
    end
    rdy_i = '0;
  endtask

  task automatic test_drop_offer;
    int w;
    do_reset;
    rdy_i = 4'b0010;
    w = 0;
    while (rdy !== 1'b1 && w < 4) begin tick; w++; end
    rd_en = 1; done = 1;
    #1;
    checks++;
    if (rdy !== 1'b1 || f_rd_en !== '0 || f_done !== '0) begin
      failures++;
      $display("FAIL offer_ignore rdy=%b rd_en=%b done=%b want=1/0/0", rdy, f_rd_en, f_done);
    end
    rd_en = 0; done = 0;
    rdy_i[1] = 0;
    #1;
    checks++;
    if (ack_o !== '0) begin failures++; $display("FAIL drop_ack got=%b want=0", ack_o); end
    tick;
    checks++;
    if (rdy !== 1'b0) begin failures++; $display("FAIL drop_rdy got=%b want=0", rdy); end
    ack = 1;
    #1;
    checks++;
    if (ack_o !== '0 || rdy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack got=%b/%b want=0/0", ack_o, rdy);
    end
    tick;
    ack = 0;
  endtask

  task automatic test_slow_done_ack;
    int g;
    do_reset;
    rdy_i = 4'b0011;
    rbase = 40;
    serve(2, 5, g);
    checks++;
    if (g !== 0) begin failures++; $display("FAIL slow_first got=%0d want=0", g); end
    serve(1, 0, g);
    checks++;
    if (g !== 1) begin failures++; $display("FAIL slow_next got=%0d want=1", g); end
    rdy_i = '0;
  endtask

  task automatic test_reset_busy;
    int w, g;
    do_reset;
    rdy_i = 4'b1000;
    w = 0;
    while (rdy !== 1'b1 && w < 4) begin tick; w++; end
    ack = 1;
    tick;
    ack = 0;
    rd_en = 1; done = 1;
    #1;
    checks++;
    if (f_rd_en !== 4'b1000 || f_done !== 4'b1000) begin
      failures++;
      $display("FAIL busy3 rd_en=%b done=%b want=1000/1000", f_rd_en, f_done);
    end
    rst = 1;
    tick;
    checks++;
    if ({rdy, done_ack, rd_vld} !== '0 || rd_data !== '0 || byte_len !== '0 ||
        {f_rd_en, f_done, ack_o} !== '0) begin
      failures++;
      $display("FAIL rst_busy rdy=%b dack=%b vld=%b data=%h len=%h strobes=%b",
               rdy, done_ack, rd_vld, rd_data, byte_len, {f_rd_en, f_done, ack_o});
    end
    rst = 0; rd_en = 0; done = 0;
    last_srv = N - 1;
    w = 0;
    while (rdy !== 1'b1 && w < 2) begin tick; w++; end
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL reoffer rdy=%b want=1", rdy); end
    serve(1, 1, g);
    checks++;
    if (g !== 3) begin failures++; $display("FAIL reoffer_core got=%0d want=3", g); end
    rdy_i = '0;
  endtask

  task automatic test_out_reg;
    int w;
    do_reset;
    lens[1] = 32'h5EA;
    rdy_i = 4'b0010;
    w = 0;
    while (rdy !== 1'b1 && w < 4) begin tick; w++; end
    tick;
    checks++;
    if (byte_len1 !== 32'h5EA) begin failures++; $display("FAIL reg_len got=%h want=5ea", byte_len1); end
    ack = 1;
    tick;
    ack = 0;
    addr = 8'h07;
    rd_en = 1;
    tick;
    rd_en = 0;
    checks++;
    if (rd_vld1 !== 1'b0 || rd_vld !== 1'b1) begin
      failures++;
      $display("FAIL reg_vld1 got=%b/%b want=0/1", rd_vld1, rd_vld);
    end
    tick;
    checks++;
    if (rd_vld1 !== 1'b1 || rd_data1 !== mk(1, 8'h07)) begin
      failures++;
      $display("FAIL reg_vld2 got=%b/%h want=1/%h", rd_vld1, rd_data1, mk(1, 8'h07));
    end
    done = 1;
    dack_i = 4'b0010;
    tick;
    done = 0;
    dack_i = '0;
    last_srv = 1;
    rdy_i = '0;
  endtask

  task automatic test_random;
    int g;
    do_reset;
    for (int k = 0; k < N; k++) lens[k] = $urandom;
    for (int p = 0; p < 16; p++) begin
      rdy_i = N'($urandom_range(1, 15));
      rbase = $urandom_range(0, 200);
      serve($urandom_range(1, 3), $urandom_range(0, 3), g);
    end
    rdy_i = '0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) lens[k] = 32'h100 + 32'(k);
    rst = 1; rd_en = 0; done = 0; ack = 0; addr = '0; dack_i = '0; rdy_i = '0;
    test_reset;
    test_single_core;
    test_round_robin;
    test_drop_offer;
    test_slow_done_ack;
    test_reset_busy;
    test_out_reg;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
